// File: rtl/cam_mode_controller_if.sv
// Purpose: bundles the IR/camera inputs and mode/drive outputs of cam_mode_controller.
// Latency: none, signal container only.
// Backpressure: none, all signals are level-sampled every cycle.
interface cam_mode_controller_if #(
  parameter int CMD_W = 8
);
  logic [CMD_W-1:0] ir_button;
  logic [2:0]       cam_direction;
  logic [1:0]       speed;
  logic             orange_detected;
  logic [2:0]       ir_drive;
  logic [1:0]       state;
  logic [1:0]       cam_state;
  logic [2:0]       drive_state;
  logic             mode_reset;
  logic             search_timeout;

  modport master (
    output ir_button, cam_direction, speed, orange_detected, ir_drive,
    input  state, cam_state, drive_state, mode_reset, search_timeout
  );

  modport slave (
    input  ir_button, cam_direction, speed, orange_detected, ir_drive,
    output state, cam_state, drive_state, mode_reset, search_timeout
  );
endinterface

// File: rtl/cam_mode_controller.sv
// Purpose: debounced IR command filter, IDLE/CAM/IR mode FSM, CAM SEARCH/FOLLOW/PAUSE sub-FSM, drive select.
// Latency: command visible CMD_HOLD cycles after first presentation; detection/lost/timeout effects 1 cycle, all outputs registered.
// Backpressure: none, inputs sampled every cycle. Optional macro CAM_SEARCH_TIMEOUT_EN enables the SEARCH timeout.
module cam_mode_controller #(
  parameter int               CMD_W          = 8,
  parameter logic [CMD_W-1:0] CMD_CAM        = 8'h0F,
  parameter logic [CMD_W-1:0] CMD_IR         = 8'h13,
  parameter logic [CMD_W-1:0] CMD_IDLE       = 8'h10,
  parameter int               CMD_HOLD       = 4,
  parameter int               LOST_HOLD      = 16,
  parameter int               SEARCH_TIMEOUT = 1000
) (
  input logic                  clk_50,
  input logic                  reset_n,
  cam_mode_controller_if.slave bus
);

  localparam int CNT_W  = $clog2(CMD_HOLD + 1);
  localparam int LOST_W = $clog2(LOST_HOLD + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_CAM = 2'b01, ST_IR = 2'b10} mode_e;
  typedef enum logic [1:0] {CS_SEARCH = 2'b00, CS_FOLLOW = 2'b01, CS_PAUSE = 2'b11} cam_e;

  localparam logic [2:0] DRV_STOP   = 3'b000;
  localparam logic [2:0] DRV_LEFT   = 3'b001;
  localparam logic [2:0] DRV_RIGHT  = 3'b010;
  localparam logic [2:0] DRV_SLOW   = 3'b011;
  localparam logic [2:0] DRV_MEDIUM = 3'b100;
  localparam logic [2:0] DRV_FAST   = 3'b101;

  logic [CMD_W-1:0]  last_code;
  logic [CNT_W-1:0]  cmd_cnt, cmd_cnt_nxt;
  logic              accept;
  mode_e             state_q, state_nxt;
  cam_e              cam_q, cam_nxt;
  logic [2:0]        drive_q, drive_nxt;
  logic              mode_reset_q, mode_reset_nxt;
  logic [LOST_W-1:0] lost_cnt, lost_nxt;

`ifdef CAM_SEARCH_TIMEOUT_EN
  localparam int SRCH_W = $clog2(SEARCH_TIMEOUT + 1);
  logic [SRCH_W-1:0] srch_cnt, srch_nxt;
  logic              timeout_q, timeout_nxt;
`else
  logic unused_search_timeout;
  assign unused_search_timeout = (SEARCH_TIMEOUT > 0);
`endif

  // Camera steering in FOLLOW: sideways turns, or speed-graded forward when target is ahead.
  function automatic logic [2:0] follow_drive(input logic [2:0] dir, input logic [1:0] spd);
    logic [2:0] d;
    d = DRV_STOP;
    case (dir)
      3'b001: d = DRV_LEFT;
      3'b010: d = DRV_RIGHT;
      3'b011: begin
        case (spd)
          2'b00:   d = DRV_SLOW;
          2'b01:   d = DRV_MEDIUM;
          2'b10:   d = DRV_FAST;
          default: d = DRV_STOP;
        endcase
      end
      default: d = DRV_STOP;
    endcase
    return d;
  endfunction

  // Command filter: count consecutive identical codes, accept a known code exactly once when the count hits CMD_HOLD.
  always_comb begin
    cmd_cnt_nxt = cmd_cnt;
    accept      = 1'b0;
    if (bus.ir_button != last_code)
      cmd_cnt_nxt = CNT_W'(1);
    else if (cmd_cnt != CNT_W'(CMD_HOLD))
      cmd_cnt_nxt = cmd_cnt + CNT_W'(1);
    // A saturated counter on an unchanged code means it was already accepted.
    if ((cmd_cnt_nxt == CNT_W'(CMD_HOLD)) &&
        !((bus.ir_button == last_code) && (cmd_cnt == CNT_W'(CMD_HOLD))) &&
        ((bus.ir_button == CMD_CAM) || (bus.ir_button == CMD_IR) || (bus.ir_button == CMD_IDLE)))
      accept = 1'b1;
  end

  // Mode and CAM sub-state next-state, drive select and change pulse; accepted command has top priority.
  always_comb begin
    state_nxt = state_q;
    cam_nxt   = cam_q;
    lost_nxt  = lost_cnt;
    drive_nxt = drive_q;
`ifdef CAM_SEARCH_TIMEOUT_EN
    srch_nxt    = srch_cnt;
    timeout_nxt = timeout_q;
`endif
    if (accept) begin
      if (bus.ir_button == CMD_CAM) begin
        state_nxt = ST_CAM;
        cam_nxt   = CS_SEARCH;
        lost_nxt  = '0;
`ifdef CAM_SEARCH_TIMEOUT_EN
        srch_nxt    = '0;
        timeout_nxt = 1'b0;
`endif
      end else if (bus.ir_button == CMD_IR) begin
        state_nxt = ST_IR;
        cam_nxt   = CS_PAUSE;
      end else begin
        state_nxt = ST_IDLE;
        cam_nxt   = CS_PAUSE;
      end
    end else if (state_q == ST_CAM) begin
      case (cam_q)
        CS_SEARCH: begin
          if (bus.orange_detected) begin
            cam_nxt  = CS_FOLLOW;
            lost_nxt = '0;
`ifdef CAM_SEARCH_TIMEOUT_EN
            srch_nxt = '0;
          end else if (srch_cnt == SRCH_W'(SEARCH_TIMEOUT - 1)) begin
            cam_nxt     = CS_PAUSE;
            srch_nxt    = '0;
            timeout_nxt = 1'b1;
          end else begin
            srch_nxt = srch_cnt + SRCH_W'(1);
`endif
          end
        end
        CS_FOLLOW: begin
          if (bus.orange_detected) begin
            lost_nxt = '0;
          end else if (lost_cnt == LOST_W'(LOST_HOLD - 1)) begin
            cam_nxt  = CS_SEARCH;
            lost_nxt = '0;
`ifdef CAM_SEARCH_TIMEOUT_EN
            srch_nxt = '0;
`endif
          end else begin
            lost_nxt = lost_cnt + LOST_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Drive follows the state being entered; FOLLOW without detection keeps its last command.
    case (state_nxt)
      ST_IR:  drive_nxt = (bus.ir_drive > DRV_FAST) ? DRV_STOP : bus.ir_drive;
      ST_CAM: begin
        case (cam_nxt)
          CS_SEARCH: drive_nxt = DRV_RIGHT;
          CS_FOLLOW: if (bus.orange_detected)
                       drive_nxt = follow_drive(bus.cam_direction, bus.speed);
          default:   drive_nxt = DRV_STOP;
        endcase
      end
      default: drive_nxt = DRV_STOP;
    endcase

    mode_reset_nxt = (state_nxt != state_q) || (cam_nxt != cam_q);
  end

  // Registered filter, FSM state and outputs.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      last_code    <= '0;
      cmd_cnt      <= '0;
      state_q      <= ST_IDLE;
      cam_q        <= CS_PAUSE;
      drive_q      <= DRV_STOP;
      mode_reset_q <= 1'b0;
      lost_cnt     <= '0;
    end else begin
      last_code    <= bus.ir_button;
      cmd_cnt      <= cmd_cnt_nxt;
      state_q      <= state_nxt;
      cam_q        <= cam_nxt;
      drive_q      <= drive_nxt;
      mode_reset_q <= mode_reset_nxt;
      lost_cnt     <= lost_nxt;
    end
  end

`ifdef CAM_SEARCH_TIMEOUT_EN
  // SEARCH cycle counter and sticky timeout flag.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      srch_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      srch_cnt  <= srch_nxt;
      timeout_q <= timeout_nxt;
    end
  end
  assign bus.search_timeout = timeout_q;
`else
  assign bus.search_timeout = 1'b0;
`endif

  assign bus.state       = state_q;
  assign bus.cam_state   = cam_q;
  assign bus.drive_state = drive_q;
  assign bus.mode_reset  = mode_reset_q;

endmodule

// File: tb/tb_cam_mode_controller.sv
// Purpose: directed self-checking bench for cam_mode_controller (default parameters, SEARCH_TIMEOUT=20).
// Latency: inputs change on falling edges, outputs sampled on the following falling edge.
// Backpressure: none.
module tb_cam_mode_controller;
  logic clk_50 = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #10 clk_50 = ~clk_50;

  cam_mode_controller_if #(.CMD_W(8)) bus();

  cam_mode_controller #(.SEARCH_TIMEOUT(20)) dut (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.ir_button = 8'h00; bus.cam_direction = 3'b000; bus.speed = 2'b00;
    bus.orange_detected = 1'b0; bus.ir_drive = 3'b000;
    #1 reset_n = 1'b0;
    #4;
    if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", bus.state); end checks++;
    if (bus.cam_state !== 2'b11) begin errors++; $display("FAIL reset_cam got %b want 11", bus.cam_state); end checks++;
    if (bus.drive_state !== 3'b000) begin errors++; $display("FAIL reset_drive got %b want 000", bus.drive_state); end checks++;
    if (bus.mode_reset !== 1'b0) begin errors++; $display("FAIL reset_mode_reset got %b want 0", bus.mode_reset); end checks++;
    if (bus.search_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.search_timeout); end checks++;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_short_hold();
    bus.ir_button = 8'h0F;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      if (bus.state !== 2'b00 || bus.mode_reset !== 1'b0) begin errors++; $display("FAIL short_hold cycle %0d state %b mr %b want 00/0", i, bus.state, bus.mode_reset); end checks++;
    end
    bus.ir_button = 8'h00;
    tick(2);
    if (bus.state !== 2'b00) begin errors++; $display("FAIL short_hold_after state %b want 00", bus.state); end checks++;
  endtask

  task automatic test_cam_entry();
    bus.ir_button = 8'h0F;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      if (bus.state !== 2'b00) begin errors++; $display("FAIL cam_entry_early cycle %0d state %b want 00", i, bus.state); end checks++;
    end
    tick(1);
    if (bus.state !== 2'b01) begin errors++; $display("FAIL cam_entry state %b want 01", bus.state); end checks++;
    if (bus.cam_state !== 2'b00) begin errors++; $display("FAIL cam_entry cam %b want 00", bus.cam_state); end checks++;
    if (bus.drive_state !== 3'b010) begin errors++; $display("FAIL cam_entry drive %b want 010", bus.drive_state); end checks++;
    if (bus.mode_reset !== 1'b1) begin errors++; $display("FAIL cam_entry mode_reset %b want 1", bus.mode_reset); end checks++;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      if (bus.mode_reset !== 1'b0 || bus.state !== 2'b01) begin errors++; $display("FAIL cam_entry_hold cycle %0d mr %b state %b want 0/01", i, bus.mode_reset, bus.state); end checks++;
    end
    bus.ir_button = 8'h00;
  endtask

  task automatic test_follow();
    bus.orange_detected = 1'b1; bus.cam_direction = 3'b011; bus.speed = 2'b01;
    tick(1);
    if (bus.cam_state !== 2'b01) begin errors++; $display("FAIL follow_entry cam %b want 01", bus.cam_state); end checks++;
    if (bus.drive_state !== 3'b100) begin errors++; $display("FAIL follow_entry drive %b want 100", bus.drive_state); end checks++;
    if (bus.mode_reset !== 1'b1) begin errors++; $display("FAIL follow_entry mode_reset %b want 1", bus.mode_reset); end checks++;
    bus.speed = 2'b11;
    tick(1);
    if (bus.drive_state !== 3'b000) begin errors++; $display("FAIL follow_stop drive %b want 000", bus.drive_state); end checks++;
    if (bus.mode_reset !== 1'b0) begin errors++; $display("FAIL follow_stop mode_reset %b want 0", bus.mode_reset); end checks++;
    bus.cam_direction = 3'b001; tick(1);
    if (bus.drive_state !== 3'b001) begin errors++; $display("FAIL follow_left drive %b want 001", bus.drive_state); end checks++;
    bus.cam_direction = 3'b010; tick(1);
    if (bus.drive_state !== 3'b010) begin errors++; $display("FAIL follow_right drive %b want 010", bus.drive_state); end checks++;
    bus.cam_direction = 3'b111; tick(1);
    if (bus.drive_state !== 3'b000) begin errors++; $display("FAIL follow_none drive %b want 000", bus.drive_state); end checks++;
    bus.cam_direction = 3'b011; bus.speed = 2'b10; tick(1);
    if (bus.drive_state !== 3'b101) begin errors++; $display("FAIL follow_fast drive %b want 101", bus.drive_state); end checks++;
  endtask

  task automatic test_lost();
    bus.orange_detected = 1'b0; bus.speed = 2'b00;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      if (bus.cam_state !== 2'b01 || bus.drive_state !== 3'b101) begin errors++; $display("FAIL lost_window1 cycle %0d cam %b drive %b want 01/101", i, bus.cam_state, bus.drive_state); end checks++;
    end
    bus.orange_detected = 1'b1; tick(1);
    if (bus.cam_state !== 2'b01 || bus.drive_state !== 3'b011) begin errors++; $display("FAIL lost_redetect cam %b drive %b want 01/011", bus.cam_state, bus.drive_state); end checks++;
    bus.orange_detected = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      if (bus.cam_state !== 2'b01 || bus.drive_state !== 3'b011) begin errors++; $display("FAIL lost_window2 cycle %0d cam %b drive %b want 01/011", i, bus.cam_state, bus.drive_state); end checks++;
    end
    tick(1);
    if (bus.cam_state !== 2'b00) begin errors++; $display("FAIL lost_expiry cam %b want 00", bus.cam_state); end checks++;
    if (bus.drive_state !== 3'b010) begin errors++; $display("FAIL lost_expiry drive %b want 010", bus.drive_state); end checks++;
    if (bus.mode_reset !== 1'b1) begin errors++; $display("FAIL lost_expiry mode_reset %b want 1", bus.mode_reset); end checks++;
    tick(1);
    if (bus.mode_reset !== 1'b0) begin errors++; $display("FAIL lost_expiry_next mode_reset %b want 0", bus.mode_reset); end checks++;
  endtask

`ifdef CAM_SEARCH_TIMEOUT_EN
  task automatic test_search_timeout();
    bus.ir_button = 8'h0F; tick(4);
    bus.ir_button = 8'h00;
    for (int i = 1; i <= 19; i++) begin
      tick(1);
      if (bus.cam_state !== 2'b00) begin errors++; $display("FAIL timeout_early cycle %0d cam %b want 00", i, bus.cam_state); end checks++;
    end
    tick(1);
    if (bus.cam_state !== 2'b11 || bus.search_timeout !== 1'b1) begin errors++; $display("FAIL timeout cam %b flag %b want 11/1", bus.cam_state, bus.search_timeout); end checks++;
    if (bus.drive_state !== 3'b000 || bus.mode_reset !== 1'b1 || bus.state !== 2'b01) begin errors++; $display("FAIL timeout drive %b mr %b state %b want 000/1/01", bus.drive_state, bus.mode_reset, bus.state); end checks++;
    tick(1);
    if (bus.mode_reset !== 1'b0 || bus.search_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky mr %b flag %b want 0/1", bus.mode_reset, bus.search_timeout); end checks++;
    bus.ir_button = 8'h0F; tick(4);
    bus.ir_button = 8'h00;
    if (bus.cam_state !== 2'b00 || bus.search_timeout !== 1'b0) begin errors++; $display("FAIL timeout_reenter cam %b flag %b want 00/0", bus.cam_state, bus.search_timeout); end checks++;
    if (bus.drive_state !== 3'b010 || bus.mode_reset !== 1'b1) begin errors++; $display("FAIL timeout_reenter drive %b mr %b want 010/1", bus.drive_state, bus.mode_reset); end checks++;
  endtask
`else
  task automatic test_search_persist();
    bus.ir_button = 8'h0F; tick(4);
    bus.ir_button = 8'h00;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (bus.cam_state !== 2'b00 || bus.search_timeout !== 1'b0 || bus.drive_state !== 3'b010) begin errors++; $display("FAIL search_persist cycle %0d cam %b flag %b drive %b want 00/0/010", i, bus.cam_state, bus.search_timeout, bus.drive_state); end checks++;
    end
  endtask
`endif

  task automatic test_ir();
    int pulses;
    pulses = 0;
    bus.ir_drive = 3'b001; bus.ir_button = 8'h13;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (bus.mode_reset === 1'b1) pulses++;
      if (i == 3) begin
        if (bus.state !== 2'b01) begin errors++; $display("FAIL ir_early state %b want 01", bus.state); end checks++;
      end
      if (i == 4) begin
        if (bus.state !== 2'b10 || bus.cam_state !== 2'b11 || bus.drive_state !== 3'b001) begin errors++; $display("FAIL ir_entry state %b cam %b drive %b want 10/11/001", bus.state, bus.cam_state, bus.drive_state); end checks++;
      end
    end
    if (pulses !== 1) begin errors++; $display("FAIL ir_pulses got %0d want 1", pulses); end checks++;
    bus.ir_button = 8'h00;
    bus.ir_drive = 3'b111; tick(1);
    if (bus.drive_state !== 3'b000) begin errors++; $display("FAIL ir_invalid drive %b want 000", bus.drive_state); end checks++;
    bus.ir_drive = 3'b101; tick(1);
    if (bus.drive_state !== 3'b101) begin errors++; $display("FAIL ir_fast drive %b want 101", bus.drive_state); end checks++;
    bus.ir_button = 8'h10; tick(3);
    if (bus.state !== 2'b10) begin errors++; $display("FAIL idle_early state %b want 10", bus.state); end checks++;
    tick(1);
    if (bus.state !== 2'b00 || bus.drive_state !== 3'b000 || bus.mode_reset !== 1'b1) begin errors++; $display("FAIL idle_entry state %b drive %b mr %b want 00/000/1", bus.state, bus.drive_state, bus.mode_reset); end checks++;
    bus.ir_button = 8'h00;
  endtask

  task automatic test_unrecognised();
    bus.ir_button = 8'h55;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (bus.state !== 2'b00 || bus.mode_reset !== 1'b0) begin errors++; $display("FAIL unrecognised cycle %0d state %b mr %b want 00/0", i, bus.state, bus.mode_reset); end checks++;
    end
    bus.ir_button = 8'h00; tick(1);
  endtask

  task automatic test_back_to_back();
    bus.ir_button = 8'h0F; tick(4);
    if (bus.state !== 2'b01) begin errors++; $display("FAIL b2b_cam state %b want 01", bus.state); end checks++;
    bus.ir_button = 8'h13; tick(3);
    if (bus.state !== 2'b01) begin errors++; $display("FAIL b2b_ir_early state %b want 01", bus.state); end checks++;
    tick(1);
    if (bus.state !== 2'b10 || bus.mode_reset !== 1'b1) begin errors++; $display("FAIL b2b_ir state %b mr %b want 10/1", bus.state, bus.mode_reset); end checks++;
    bus.ir_button = 8'h10; tick(4);
    if (bus.state !== 2'b00 || bus.cam_state !== 2'b11) begin errors++; $display("FAIL b2b_idle state %b cam %b want 00/11", bus.state, bus.cam_state); end checks++;
    bus.ir_button = 8'h00; tick(1);
  endtask

  task automatic test_async_reset();
    bus.ir_button = 8'h0F; tick(4);
    bus.ir_button = 8'h00;
    bus.orange_detected = 1'b1; bus.cam_direction = 3'b011; bus.speed = 2'b10;
    tick(1);
    if (bus.cam_state !== 2'b01 || bus.drive_state !== 3'b101) begin errors++; $display("FAIL areset_setup cam %b drive %b want 01/101", bus.cam_state, bus.drive_state); end checks++;
    #5 reset_n = 1'b0;
    #1;
    if (bus.state !== 2'b00 || bus.cam_state !== 2'b11) begin errors++; $display("FAIL areset state %b cam %b want 00/11", bus.state, bus.cam_state); end checks++;
    if (bus.drive_state !== 3'b000 || bus.mode_reset !== 1'b0 || bus.search_timeout !== 1'b0) begin errors++; $display("FAIL areset drive %b mr %b flag %b want 000/0/0", bus.drive_state, bus.mode_reset, bus.search_timeout); end checks++;
    @(negedge clk_50);
    reset_n = 1'b1;
    bus.orange_detected = 1'b0;
    bus.ir_button = 8'h0F;
    tick(3);
    if (bus.state !== 2'b00) begin errors++; $display("FAIL areset_release_early state %b want 00", bus.state); end checks++;
    tick(1);
    if (bus.state !== 2'b01) begin errors++; $display("FAIL areset_release state %b want 01", bus.state); end checks++;
    bus.ir_button = 8'h00;
  endtask

  initial begin
    test_reset();
    test_short_hold();
    test_cam_entry();
    test_follow();
    test_lost();
`ifdef CAM_SEARCH_TIMEOUT_EN
    test_search_timeout();
`else
    test_search_persist();
`endif
    test_ir();
    test_unrecognised();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/cam_mode_controller.md
# cam_mode_controller

Parametrised top-level mode controller for the robot. Filters IR remote command codes, selects IDLE / CAM / IR operating mode, runs the CAM sub-state machine (SEARCH / FOLLOW / PAUSE) with lost-target hysteresis and a search timeout, and issues a registered 3-bit drive command to the motor block. It replaces the fixed-code mode FSM and adds debounced command acceptance, an IR-mode drive path and a one-cycle sub-block reset pulse on every mode change.

## Interface
- CMD_W, 8, width of IR command code
- CMD_CAM, 8'h0F, code selecting CAM mode
- CMD_IR, 8'h13, code selecting IR mode
- CMD_IDLE, 8'h10, code selecting IDLE mode
- CMD_HOLD, 4, consecutive cycles (>=1) a code must be stable to be accepted
- LOST_HOLD, 16, consecutive cycles (>=1) of no detection before FOLLOW→SEARCH
- SEARCH_TIMEOUT, 1000, SEARCH cycles (>=1) before timeout (only with macro)
- clk_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- ir_button  in  CMD_W  decoded IR code, 0 when no key
- cam_direction  in  3  001 LEFT, 010 RIGHT, 011 ahead, other = none
- speed  in  2  00 slow, 01 medium, 10 fast, 11 stop
- orange_detected  in  1  target present this cycle
- ir_drive  in  3  drive command from IR manual path
- state  out  2  00 IDLE, 01 CAM, 10 IR
- cam_state  out  2  00 SEARCH, 01 FOLLOW, 11 PAUSE
- drive_state  out  3  000 STOP, 001 LEFT, 010 RIGHT, 011 SLOW, 100 MEDIUM, 101 FAST
- mode_reset  out  1  one-cycle pulse to downstream blocks on any state/cam_state change
- search_timeout  out  1  sticky: last SEARCH ended by timeout

## Operation
- Command filter: register last code and a saturating stable counter; counter resets to 1 when code changes. A code equal to CMD_CAM/CMD_IR/CMD_IDLE is accepted once, on the cycle its count reaches CMD_HOLD; it must change (e.g. to 0) before it can be accepted again. Unrecognised codes never accepted.
- Mode transitions on accepted command: any mode → commanded mode. Accepting the current mode's own code: IDLE/IR no change; CAM restarts at SEARCH and clears search_timeout.
- Entering CAM: cam_state = SEARCH, search_timeout cleared. Leaving CAM: cam_state = PAUSE.
- SEARCH → FOLLOW when orange_detected = 1. FOLLOW → SEARCH when orange_detected = 0 for LOST_HOLD consecutive cycles; a single detected cycle restarts the lost count.
- Drive: IDLE → STOP; IR → ir_drive (values >101 map to STOP); CAM/SEARCH → RIGHT; CAM/PAUSE → STOP; CAM/FOLLOW → LEFT/RIGHT per cam_direction, 011 maps speed 00/01/10/11 → SLOW/MEDIUM/FAST/STOP, other directions → STOP. During the lost window FOLLOW drive holds its last value.
- Priority same cycle: accepted command > detection > lost count expiry > timeout.
- mode_reset = 1 for exactly the first cycle in which a new state or cam_state value is visible; never two consecutive cycles for one change.

## Timing
- All outputs registered. Reset values: state IDLE, cam_state PAUSE, drive_state STOP, mode_reset 0, search_timeout 0; all counters 0.
- Code first present before edge k: new state visible after edge k+CMD_HOLD-1 (CMD_HOLD cycles), drive_state updated same edge, mode_reset high that cycle.
- orange_detected high before edge k in SEARCH: cam_state FOLLOW and drive updated after edge k.
- Lost expiry: cam_state SEARCH visible after the LOST_HOLD-th consecutive low sample.
- reset_n assertion mid-operation returns all outputs to reset values immediately (asynchronous); release synchronous to clk_50, first command counting starts on next edge.

## Configuration
- CAM_SEARCH_TIMEOUT_EN defined: SEARCH counts cycles; after SEARCH_TIMEOUT consecutive SEARCH cycles without detection cam_state → PAUSE, drive STOP, search_timeout = 1 (sticky until CAM re-entry or reset), mode_reset pulses; state stays CAM.
- Undefined: no counter, SEARCH persists indefinitely, search_timeout tied 0, SEARCH_TIMEOUT ignored.

## Test plan
- Reset, hold ir_button=8'h0F for 4 cycles → state 01, cam_state 00, drive 010, mode_reset one-cycle pulse at cycle 4; 3-cycle hold → no change.
- CAM/SEARCH, orange_detected=1, cam_direction=011, speed=01 → cam_state 01, drive 100 next cycle; speed=11 → drive 000.
- FOLLOW, drop detection 15 cycles then 1 high then 16 low → stays FOLLOW until 16th low sample, then SEARCH, drive 010, mode_reset pulse.
- Hold 8'h13 10 cycles → single transition to IR, ir_drive=001 → drive 001; ir_drive=111 → 000; 8'h10 held 4 cycles → IDLE, drive 000.
- With CAM_SEARCH_TIMEOUT_EN, SEARCH_TIMEOUT=20, no detection → after 20 cycles cam_state 11, search_timeout 1, drive 000; re-send 8'h0F → SEARCH, search_timeout 0.
- Assert reset_n mid-FOLLOW → outputs immediately IDLE/PAUSE/STOP/0/0 without a clock edge.
